// File: rtl/fpr_writeback.sv
// Writeback stage in front of the 16 x 64-bit FP register file: arbitrates alu results against a
// buffered load FIFO, registers the single write port and tracks pending destinations.
// Optional macro FPR_WB_BYPASS_EN forwards the registered write onto ft_data/fs_data.
module fpr_writeback #(
  parameter int LD_DEPTH   = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [3:0]  alu_fd,
  input  logic [1:0]  alu_wr,
  input  logic [63:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [3:0]  ld_fd,
  input  logic [1:0]  ld_wr,
  input  logic [63:0] ld_data,
  input  logic        iss_valid,
  input  logic [3:0]  iss_fd,
  input  logic [3:0]  ft,
  input  logic [3:0]  fs,
  output logic        pend_ft,
  output logic        pend_fs,
  input  logic [63:0] rf_ft,
  input  logic [63:0] rf_fs,
  output logic [63:0] ft_data,
  output logic [63:0] fs_data,
  output logic [1:0]  wr,
  output logic [3:0]  fd,
  output logic [63:0] din
);

  localparam int PW = $clog2(LD_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(LD_DEPTH);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [1:0]    fifo_wr_q   [LD_DEPTH];
  logic [3:0]    fifo_fd_q   [LD_DEPTH];
  logic [63:0]   fifo_data_q [LD_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [1:0]    wr_q, wr_d;
  logic [3:0]    fd_q, fd_d;
  logic [63:0]   din_q, din_d;
  logic [15:0]   pend_q, pend_d;
  logic          fifo_full, fifo_nonempty, force_ld, push, alu_win, ld_win;
  logic          fwd_ft, fwd_fs;

  // Both channels are valid/ready: a transfer happens in a cycle where valid and ready are both
  // high; ready never depends on the same channel's payload, and both readies drop during reset.
  assign fifo_full     = (count_q == FULL_CNT);
  assign fifo_nonempty = (count_q != '0);
  assign force_ld      = fifo_nonempty && (starve_q == STARVE_LIM);
  assign ld_ready      = !rst && !fifo_full;
  assign alu_ready     = !rst && !force_ld;
  assign push          = ld_valid && ld_ready;
  assign alu_win       = alu_valid && alu_ready;
  assign ld_win        = fifo_nonempty && (!alu_valid || force_ld);

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    starve_d = starve_q;
    wr_d     = 2'b00;
    fd_d     = fd_q;
    din_d    = din_q;
    pend_d   = pend_q;
    if (push)   wptr_d = wptr_q + 1'b1;
    if (ld_win) rptr_d = rptr_q + 1'b1;
    case ({push, ld_win})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (!fifo_nonempty || ld_win) begin
      starve_d = '0;
    end else if (alu_win && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 1'b1;
    end
    if (alu_win) begin
      wr_d  = alu_wr;
      fd_d  = alu_fd;
      din_d = alu_data;
    end else if (ld_win) begin
      wr_d  = fifo_wr_q[rptr_q];
      fd_d  = fifo_fd_q[rptr_q];
      din_d = fifo_data_q[rptr_q];
    end
    // Clear when the file commits; a same-cycle issue to the same index must win.
    if (wr_q != 2'b00) pend_d[fd_q] = 1'b0;
    if (iss_valid)     pend_d[iss_fd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      wr_q     <= 2'b00;
      fd_q     <= 4'd0;
      din_q    <= 64'd0;
      pend_q   <= 16'd0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      wr_q     <= wr_d;
      fd_q     <= fd_d;
      din_q    <= din_d;
      pend_q   <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wr_q[wptr_q]   <= ld_wr;
      fifo_fd_q[wptr_q]   <= ld_fd;
      fifo_data_q[wptr_q] <= ld_data;
    end
  end

`ifdef FPR_WB_BYPASS_EN
  assign fwd_ft  = (wr_q != 2'b00) && (fd_q == ft);
  assign fwd_fs  = (wr_q != 2'b00) && (fd_q == fs);
  assign ft_data = fwd_ft ? {(wr_q[1] ? din_q[63:32] : rf_ft[63:32]),
                             (wr_q[0] ? din_q[31:0]  : rf_ft[31:0])} : rf_ft;
  assign fs_data = fwd_fs ? {(wr_q[1] ? din_q[63:32] : rf_fs[63:32]),
                             (wr_q[0] ? din_q[31:0]  : rf_fs[31:0])} : rf_fs;
`else
  assign fwd_ft  = 1'b0;
  assign fwd_fs  = 1'b0;
  assign ft_data = rf_ft;
  assign fs_data = rf_fs;
`endif

  assign pend_ft = pend_q[ft] && !fwd_ft;
  assign pend_fs = pend_q[fs] && !fwd_fs;
  assign wr      = wr_q;
  assign fd      = fd_q;
  assign din     = din_q;

endmodule
